// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: valid/ready handshake bundle carrying one pipeline-stage entry.
//
// Signals
//   valid  entry on pc/data/bd/exc/ovf is valid
//   ready  receiver accepts the entry this cycle
//   pc     entry PC
//   data   packed payload (instr|RD2|ALUresult|MUresult)
//   bd     branch-delay flag
//   exc    exception code (0 = none)
//   ovf    arithmetic overflow
//
// Modports
//   master  drives the entry, samples ready
//   slave   samples the entry, drives ready
interface pipe_stage_skid_if #(
   parameter int unsigned DATA_W = 128,
   parameter int unsigned PC_W   = 32,
   parameter int unsigned EXC_W  = 5
) ();

   logic              valid;
   logic              ready;
   logic [PC_W-1:0]   pc;
   logic [DATA_W-1:0] data;
   logic              bd;
   logic [EXC_W-1:0]  exc;
   logic              ovf;

   modport master (
      output valid,
      output pc,
      output data,
      output bd,
      output exc,
      output ovf,
      input  ready
   );

   modport slave (
      input  valid,
      input  pc,
      input  data,
      input  bd,
      input  exc,
      input  ovf,
      output ready
   );

endinterface

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic two-entry (head + skid) pipeline register between stages.
//
// Holds PC, packed payload, branch-delay flag, exception code and overflow for one
// stage. in_ready depends only on registered occupancy, so a downstream stall never
// reaches upstream combinationally. Outputs come straight from the head register.
//
// Ports
//   clk     clock, all state on posedge
//   reset   synchronous active-high reset (head PC <= RESET_PC)
//   req     exception flush: empties both entries, head PC <= HANDLER_PC
//   in_if   upstream entry (slave side of the handshake)
//   out_if  head entry (master side of the handshake)
//   occ     number of entries held: 0, 1 or 2
//
// Build option
//   PIPE_STAGE_EXC_MERGE_EN  when defined, an entry with exc==0 and ovf==1 is stored
//                            with exc = OVF_CODE; otherwise exc is stored as received.
module pipe_stage_skid #(
   parameter int unsigned     DATA_W     = 128,
   parameter int unsigned     PC_W       = 32,
   parameter int unsigned     EXC_W      = 5,
   parameter logic [PC_W-1:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000,
   parameter logic [EXC_W-1:0] OVF_CODE  = 5'd12
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req,
   pipe_stage_skid_if.slave         in_if,
   pipe_stage_skid_if.master        out_if,
   output logic [1:0]               occ
);

   // State encoding equals the occupancy count so occ is a direct copy.
   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StFull  = 2'd2
   } state_e;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [DATA_W-1:0] data;
      logic              bd;
      logic [EXC_W-1:0]  exc;
      logic              ovf;
   } entry_t;

   state_e state_q, state_d;
   entry_t head_q, head_d;
   entry_t skid_q, skid_d;
   entry_t in_entry;
   logic   push, pop;

   // Captured form of the incoming entry, including the optional exception merge.
   always_comb begin
      in_entry.pc   = in_if.pc;
      in_entry.data = in_if.data;
      in_entry.bd   = in_if.bd;
      in_entry.ovf  = in_if.ovf;
`ifdef PIPE_STAGE_EXC_MERGE_EN
      // A real exception code always wins over the overflow substitution.
      in_entry.exc  = ((in_if.exc == '0) && in_if.ovf) ? OVF_CODE : in_if.exc;
`else
      in_entry.exc  = in_if.exc;
`endif
   end

`ifndef PIPE_STAGE_EXC_MERGE_EN
   logic unused_ovf_code;
   assign unused_ovf_code = ^OVF_CODE;
`endif

   assign in_if.ready = (state_q != StFull);
   assign push        = in_if.valid & in_if.ready;
   assign pop         = out_if.valid & out_if.ready;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;

      if (req) begin
         // Flush; any entry offered this cycle is dropped.
         state_d     = StEmpty;
         head_d      = '0;
         head_d.pc   = HANDLER_PC;
         skid_d      = '0;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (push) begin
                  head_d  = in_entry;
                  state_d = StOne;
               end
            end
            StOne: begin
               if (push && pop) begin
                  head_d = in_entry;
               end else if (push) begin
                  skid_d  = in_entry;
                  state_d = StFull;
               end else if (pop) begin
                  // Head becomes a bubble but keeps the last PC.
                  head_d.data = '0;
                  head_d.bd   = 1'b0;
                  head_d.exc  = '0;
                  head_d.ovf  = 1'b0;
                  state_d     = StEmpty;
               end
            end
            StFull: begin
               if (pop) begin
                  head_d  = skid_q;
                  state_d = StOne;
               end
            end
            default: begin
               state_d = StEmpty;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StEmpty;
         head_q      <= '0;
         head_q.pc   <= RESET_PC;
         skid_q      <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
      end
   end

   assign out_if.valid = (state_q != StEmpty);
   assign out_if.pc    = head_q.pc;
   assign out_if.data  = head_q.data;
   assign out_if.bd    = head_q.bd;
   assign out_if.exc   = head_q.exc;
   assign out_if.ovf   = head_q.ovf;
   assign occ          = state_q;

endmodule
